// File: rtl/vending_pkg.sv
// Shared state encoding and coin values for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2,
    WAIT    = 2'd3
  } state_t;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

endpackage

// File: rtl/vending_change_dispenser.sv
// Decodes one change coin per cycle from the remaining amount: dimes first, then a nickel.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                done
);

  localparam logic [CREDIT_W-1:0] DIME_W   = CREDIT_W'(DIME_C);
  localparam logic [CREDIT_W-1:0] NICKEL_W = CREDIT_W'(NICKEL_C);

  logic                use_dime;
  logic [CREDIT_W-1:0] step;

  always_comb begin
    use_dime   = (amount >= DIME_W);
    step       = use_dime ? DIME_W : NICKEL_W;
    dime_out   = load && use_dime;
    nickel_out = load && !use_dime;
    // done flags the last coin, so the FSM can leave CHANGE on this edge
    done       = load && (amount == step);
  end

endmodule

// File: rtl/vending_machine_param.sv
// Programmable-price vending controller with binary credit and serial change return.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE    = 25,
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                cancel_in,
  input  logic                thanks_in,
  output logic                candy_out,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_W   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_W  = CREDIT_W'(NICKEL_C);
  localparam logic [CREDIT_W-1:0] DIME_W    = CREDIT_W'(DIME_C);
  localparam logic [CREDIT_W-1:0] QUARTER_W = CREDIT_W'(QUARTER_C);

  state_t              state;
  logic                vended;
  logic                any_coin;
  logic                multi_coin;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic                chg_nickel;
  logic                chg_dime;
  logic                chg_done;

  always_comb begin
    any_coin   = nickel_in | dime_in | quarter_in;
    multi_coin = (nickel_in & (dime_in | quarter_in)) | (dime_in & quarter_in);
    coin_val   = nickel_in ? NICKEL_W : (dime_in ? DIME_W : QUARTER_W);
    credit_sum = credit + coin_val;
  end

  vending_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .load       (state == CHANGE),
    .amount     (credit),
    .nickel_out (chg_nickel),
    .dime_out   (chg_dime),
    .done       (chg_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= '0;
      vended      <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= any_coin;
      case (state)
        COLLECT: begin
          if (cancel_in) begin
            if (credit != '0) begin
              state  <= CHANGE;
              vended <= 1'b0;
            end
          end else if (any_coin) begin
            coin_reject <= multi_coin;
            credit      <= credit_sum;
            if (credit_sum >= PRICE_W) state <= VEND;
          end
        end
        VEND: begin
          credit <= credit - PRICE_W;
          vended <= 1'b1;
          state  <= (credit != PRICE_W) ? CHANGE : WAIT;
        end
        CHANGE: begin
          credit <= credit - (chg_dime ? DIME_W : NICKEL_W);
          if (chg_done) state <= vended ? WAIT : COLLECT;
        end
        WAIT: begin
          if (thanks_in) begin
            state  <= COLLECT;
            vended <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign candy_out  = (state == VEND);
  assign nickel_out = chg_nickel;
  assign dime_out   = chg_dime;
  assign busy       = (state != COLLECT);

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed table-driven bench for vending_machine_param at PRICE=25 and PRICE=40.
module tb_vending_machine_param;

  logic clk = 1'b0;
  logic reset, nickel_in, dime_in, quarter_in, cancel_in, thanks_in;

  logic       candy_a, nout_a, dout_a, rej_a, busy_a;
  logic [6:0] credit_a;
  logic       candy_b, nout_b, dout_b, rej_b, busy_b;
  logic [6:0] credit_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vending_machine_param #(.PRICE(25), .CREDIT_W(7)) dut25 (
    .clk(clk), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
    .quarter_in(quarter_in), .cancel_in(cancel_in), .thanks_in(thanks_in),
    .candy_out(candy_a), .nickel_out(nout_a), .dime_out(dout_a),
    .coin_reject(rej_a), .busy(busy_a), .credit(credit_a)
  );

  vending_machine_param #(.PRICE(40), .CREDIT_W(7)) dut40 (
    .clk(clk), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
    .quarter_in(quarter_in), .cancel_in(cancel_in), .thanks_in(thanks_in),
    .candy_out(candy_b), .nickel_out(nout_b), .dime_out(dout_b),
    .coin_reject(rej_b), .busy(busy_b), .credit(credit_b)
  );

  // ins = {reset, nickel, dime, quarter, cancel, thanks}
  // exp = {credit[6:0], candy, nickel_out, dime_out, coin_reject, busy}
  typedef struct {
    logic [5:0]  ins;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [5:0] ins, input logic [6:0] cr, input logic [4:0] fl);
    vec_t v;
    v.ins = ins;
    v.exp = {cr, fl};
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic [5:0] ins);
    @(negedge clk);
    {reset, nickel_in, dime_in, quarter_in, cancel_in, thanks_in} = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d flags=%b, expected credit=%0d flags=%b",
               name, got[11:5], got[4:0], exp[11:5], exp[4:0]);
    end
  endtask

  initial begin
    {reset, nickel_in, dime_in, quarter_in, cancel_in, thanks_in} = 6'b100000;

    // flags: candy nout dout rej busy
    add(6'b100000, 7'd0,  5'b00000); // reset
    add(6'b000000, 7'd0,  5'b00000);
    add(6'b000100, 7'd25, 5'b10001); // quarter -> VEND
    add(6'b000000, 7'd0,  5'b00001); // WAIT, no change
    add(6'b000000, 7'd0,  5'b00001);
    add(6'b000001, 7'd0,  5'b00000); // thanks -> COLLECT
    add(6'b001000, 7'd10, 5'b00000); // dime
    add(6'b001000, 7'd20, 5'b00000); // dime
    add(6'b000100, 7'd45, 5'b10001); // quarter -> VEND
    add(6'b000000, 7'd20, 5'b00101); // dime out
    add(6'b000000, 7'd10, 5'b00101); // dime out
    add(6'b000000, 7'd0,  5'b00001); // WAIT
    add(6'b000001, 7'd0,  5'b00000);
    add(6'b010000, 7'd5,  5'b00000); // nickel
    add(6'b001000, 7'd15, 5'b00000); // dime
    add(6'b000010, 7'd15, 5'b00101); // cancel -> dime out
    add(6'b000000, 7'd5,  5'b01001); // nickel out
    add(6'b000000, 7'd0,  5'b00000); // back to COLLECT
    add(6'b010100, 7'd5,  5'b00010); // nickel+quarter: +5, reject
    add(6'b000000, 7'd5,  5'b00000);
    add(6'b001000, 7'd15, 5'b00000);
    add(6'b000100, 7'd40, 5'b10001); // VEND, change 15
    add(6'b000000, 7'd15, 5'b00101); // dime out
    add(6'b000100, 7'd5,  5'b01011); // quarter in CHANGE rejected
    add(6'b000000, 7'd0,  5'b00001); // WAIT
    add(6'b000001, 7'd0,  5'b00000);
    add(6'b010000, 7'd5,  5'b00000);
    add(6'b000001, 7'd5,  5'b00000); // thanks ignored in COLLECT
    add(6'b000010, 7'd5,  5'b01001); // cancel -> nickel out
    add(6'b000000, 7'd0,  5'b00000);
    add(6'b000010, 7'd0,  5'b00000); // cancel with zero credit
    add(6'b001000, 7'd10, 5'b00000);
    add(6'b001000, 7'd20, 5'b00000);
    add(6'b000100, 7'd45, 5'b10001);
    add(6'b000000, 7'd20, 5'b00101); // CHANGE in progress
    add(6'b100000, 7'd0,  5'b00000); // reset mid-CHANGE
    add(6'b000000, 7'd0,  5'b00000); // no further coins

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ins);
      check($sformatf("p25_vec%0d", i),
            {credit_a, candy_a, nout_a, dout_a, rej_a, busy_a}, vecs[i].exp);
    end

    // PRICE=40: quarter, quarter -> vend with one dime of change, then reset in WAIT
    apply(6'b100000);
    check("p40_reset", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd0, 5'b00000});
    apply(6'b000100);
    check("p40_q1", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd25, 5'b00000});
    apply(6'b000100);
    check("p40_vend", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd50, 5'b10001});
    apply(6'b000000);
    check("p40_dime", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd10, 5'b00101});
    apply(6'b000000);
    check("p40_wait", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd0, 5'b00001});
    apply(6'b010000);
    check("p40_wait_rej", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd0, 5'b00011});
    apply(6'b100000);
    check("p40_reset_wait", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd0, 5'b00000});

    // PRICE=40 exact price: four dimes, no change
    apply(6'b001000);
    apply(6'b001000);
    apply(6'b001000);
    check("p40_30", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd30, 5'b00000});
    apply(6'b001000);
    check("p40_exact", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd40, 5'b10001});
    apply(6'b000000);
    check("p40_exact_wait", {credit_b, candy_b, nout_b, dout_b, rej_b, busy_b}, {7'd0, 5'b00001});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised successor to the fixed 25-cent candy controller. It has a programmable price and a binary credit accumulator, and dispenses change serially one coin per cycle. A cancel/refund path returns all credit.

The block sits between the coin-acceptor front end (one-cycle coin pulses) and the dispense/change actuators (one-cycle pulses per item or coin). It also exports live credit and a busy flag for the display logic.

## Interface
- PRICE, 25: item price in cents. Multiple of 5, range 5..(2^CREDIT_W − 21).
- CREDIT_W, 7: credit register width. Must hold PRICE+20.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- nickel_in  in  1  5-cent coin pulse, one cycle.
- dime_in  in  1  10-cent coin pulse.
- quarter_in  in  1  25-cent coin pulse.
- cancel_in  in  1  refund request, honoured only in COLLECT.
- thanks_in  in  1  customer acknowledge after a vend.
- candy_out  out  1  one-cycle item release.
- nickel_out  out  1  one 5-cent coin returned this cycle.
- dime_out  out  1  one 10-cent coin returned this cycle.
- coin_reject  out  1  a coin pulse arrived but was not credited. The coin is routed to the return chute.
- busy  out  1  high in every state except COLLECT.
- credit  out  CREDIT_W  current credit register value, in cents.

## Operation
- States (shared enum):
  - COLLECT: accepts coins.
  - VEND
  - CHANGE
  - WAIT
- Registers:
  - state
  - credit[CREDIT_W-1:0]
  - vended (1 = CHANGE entered via VEND, 0 = via cancel)
- Reset: state=COLLECT, credit=0, vended=0. Every output is 0 in the cycle after reset.

COLLECT:
- cancel_in has top priority. If credit>0, go to CHANGE with vended=0. If credit==0, stay in COLLECT.
- Otherwise accept one coin per cycle with priority nickel > dime > quarter. Add its value to credit.
- If credit+coin ≥ PRICE, go to VEND. Otherwise stay in COLLECT.

VEND:
- candy_out=1 for this cycle.
- credit ← credit − PRICE, vended ← 1.
- Go to CHANGE if the result is greater than 0, else go to WAIT.

CHANGE:
- If credit ≥ 10: dime_out=1, credit ← credit − 10.
- Else: nickel_out=1, credit ← credit − 5.
- When the new credit is 0, leave CHANGE: go to WAIT if vended=1, else go to COLLECT.

WAIT:
- Hold until thanks_in, then go to COLLECT with vended ← 0.

coin_reject=1 when any coin input is high in a cycle where it was not credited. This covers:
- a coin arriving in VEND, CHANGE or WAIT;
- a lower-priority coin arriving alongside an accepted one;
- any coin arriving in the same cycle as an honoured cancel.

Arithmetic:
- Unsigned, CREDIT_W bits.
- credit ≤ PRICE+20 always, so overflow cannot occur.
- Change is always a multiple of 5 and never underflows.

Other inputs:
- thanks_in outside WAIT is ignored.
- cancel_in outside COLLECT is ignored.

## Timing
- Inputs are sampled on the rising edge of clk.
- candy_out, nickel_out, dime_out, busy and credit are Moore outputs, decoded from registered state and credit only.
- coin_reject is registered and appears in the cycle after the offending coin.
- Coin that reaches PRICE on edge N: candy_out is high in cycle N+1.
- Change of C cents: floor(C/10) dime cycles, then (C mod 10)/5 nickel cycles, back to back, starting in cycle N+2.
- Cancel with credit K on edge N: K is refunded over consecutive cycles from N+1, then COLLECT resumes with busy=0.
- Reset mid-CHANGE: undispensed change is discarded and no further coin pulses are issued.

## Structure
- vending_pkg holds:
  - the state enum;
  - the coin-value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25.
- One sub-module, vending_change_dispenser:
  - inputs: load, amount[CREDIT_W-1:0];
  - outputs: nickel_out, dime_out, done.
  - It serialises change for both the VEND and cancel paths.
  - The top level owns the FSM, the credit register and coin_reject.

## Test plan
- PRICE=25, quarter in COLLECT → candy_out in the next cycle, no change, WAIT. thanks_in → COLLECT, credit=0.
- PRICE=25: dime, dime, quarter (credit 45) → candy_out, then dime_out, dime_out, then WAIT.
- PRICE=25: nickel, dime (15), then cancel_in → dime_out, nickel_out, then COLLECT with busy=0 and no candy_out.
- nickel_in+quarter_in in the same cycle → credit +5, coin_reject the next cycle. A quarter during CHANGE → coin_reject, credit unaffected.
- PRICE=40: quarter, quarter (50) → candy_out, then dime_out. Reset asserted during WAIT → all outputs 0 and credit 0 the next cycle.
